// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states and field positions.
package seq_pkg;

    localparam int unsigned InstrW = 8;
    localparam int unsigned ImmW   = 4;

    localparam int unsigned OpMsb  = 7;
    localparam int unsigned OpLsb  = 6;
    localparam int unsigned DstBit = 5;
    localparam int unsigned SrcBit = 4;
    localparam int unsigned ImmMsb = 3;
    localparam int unsigned ImmLsb = 0;

    localparam logic [1:0] OpLdi = 2'b00;
    localparam logic [1:0] OpMov = 2'b01;
    localparam logic [1:0] OpAdd = 2'b10;
    localparam logic [1:0] OpHlt = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StRdS,
        StRdD,
        StWb,
        StHalt
    } seq_state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational split of an instruction word into opcode, register selects and immediate.
module instr_decode
    import seq_pkg::*;
(
    input  logic [InstrW-1:0] instr_i,
    output logic [1:0]        opcode_o,
    output logic              dst_o,
    output logic              src_o,
    output logic [ImmW-1:0]   imm_o
);

    always_comb begin
        opcode_o = instr_i[OpMsb:OpLsb];
        dst_o    = instr_i[DstBit];
        src_o    = instr_i[SrcBit];
        imm_o    = instr_i[ImmMsb:ImmLsb];
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer for a 2-register LDI/MOV/ADD/HLT machine with registered outputs.
// Optional carry flag output is built when SEQ_CARRY_FLAG_EN is defined.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [InstrW-1:0] instr_data,
    output logic              instr_ready,
    input  logic [DW-1:0]     rdata,
    output logic              rsel,
    output logic              we,
    output logic              waddr,
    output logic [DW-1:0]     wdata,
    output logic              instr_done,
    output logic              halted
`ifdef SEQ_CARRY_FLAG_EN
    ,
    output logic              carry
`endif
);

    seq_state_e        state_q, state_d;
    logic [InstrW-1:0] instr_q, instr_d;
    logic [DW-1:0]     op_s_q, op_s_d;
    logic              ready_q, ready_d;
    logic              rsel_q, rsel_d;
    logic              we_q, we_d;
    logic              waddr_q, waddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              halted_q, halted_d;
`ifdef SEQ_CARRY_FLAG_EN
    logic              carry_q, carry_d;
    logic [DW:0]       sum;
`endif

    logic [1:0]        opcode;
    logic              dst;
    logic              src;
    logic [ImmW-1:0]   imm;

    instr_decode u_decode (
        .instr_i  (instr_q),
        .opcode_o (opcode),
        .dst_o    (dst),
        .src_o    (src),
        .imm_o    (imm)
    );

    // Outputs are computed for the state being entered so they are registered yet
    // aligned with the cycle spent in that state.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        op_s_d   = op_s_q;
        ready_d  = 1'b0;
        rsel_d   = 1'b0;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        halted_d = halted_q;
`ifdef SEQ_CARRY_FLAG_EN
        carry_d  = carry_q;
        sum      = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    instr_d = instr_data;
                    state_d = StDecode;
                end else begin
                    ready_d = 1'b1;
                end
            end
            StDecode: begin
                unique case (opcode)
                    OpLdi: begin
                        state_d = StWb;
                        we_d    = 1'b1;
                        done_d  = 1'b1;
                        waddr_d = dst;
                        wdata_d = DW'(imm);
                    end
                    OpMov, OpAdd: begin
                        state_d = StRdS;
                        rsel_d  = src;
                    end
                    OpHlt: begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end
                    default: state_d = StIdle;
                endcase
            end
            StRdS: begin
                op_s_d = rdata;
                if (opcode == OpMov) begin
                    state_d = StWb;
                    we_d    = 1'b1;
                    done_d  = 1'b1;
                    waddr_d = dst;
                    wdata_d = rdata;
                end else begin
                    state_d = StRdD;
                    rsel_d  = dst;
                end
            end
            StRdD: begin
                state_d = StWb;
                we_d    = 1'b1;
                done_d  = 1'b1;
                waddr_d = dst;
`ifdef SEQ_CARRY_FLAG_EN
                sum     = {1'b0, op_s_q} + {1'b0, rdata};
                wdata_d = sum[DW-1:0];
                carry_d = sum[DW];
`else
                wdata_d = op_s_q + rdata;
`endif
            end
            StWb: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
            StHalt: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            instr_q  <= '0;
            op_s_q   <= '0;
            ready_q  <= 1'b1;
            rsel_q   <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= 1'b0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
`ifdef SEQ_CARRY_FLAG_EN
            carry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            op_s_q   <= op_s_d;
            ready_q  <= ready_d;
            rsel_q   <= rsel_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            halted_q <= halted_d;
`ifdef SEQ_CARRY_FLAG_EN
            carry_q  <= carry_d;
`endif
        end
    end

    assign instr_ready = ready_q;
    assign rsel        = rsel_q;
    assign we          = we_q;
    assign waddr       = waddr_q;
    assign wdata       = wdata_q;
    assign instr_done  = done_q;
    assign halted      = halted_q;
`ifdef SEQ_CARRY_FLAG_EN
    assign carry       = carry_q;
`endif

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: DW, default 8, datapath width; legal values 8..16; instruction width is fixed at 8.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low (0 = reset asserted).
REQ-004 instr_valid  input  1  instruction source has a word available.
REQ-005 instr_data  input  8  instruction; [7:6] opcode, [5] dst, [4] src, [3:0] imm.
REQ-006 instr_ready  output  1  sequencer can accept an instruction.
REQ-007 rdata  input  DW  regfile read data; combinational from rsel, same cycle.
REQ-008 rsel  output  1  regfile read select.
REQ-009 we  output  1  regfile write enable; the write occurs at the clock edge that ends a we=1 cycle.
REQ-010 waddr  output  1  regfile write address.
REQ-011 wdata  output  DW  regfile write data.
REQ-012 instr_done  output  1  one-cycle pulse when an instruction retires.
REQ-013 halted  output  1  sticky; HLT has executed.

Function
REQ-014 Opcodes SHALL be: 00 LDI (R[dst]=zero-extended imm), 01 MOV (R[dst]=R[src]), 10 ADD (R[dst]=R[dst]+R[src] mod 2^DW), 11 HLT.
REQ-015 FSM states SHALL be IDLE, DECODE, RD_S, RD_D, WB and HALT.
REQ-016 IDLE: instr_ready=1; on instr_valid=1, latch instr_data and go to DECODE; otherwise stay in IDLE.
REQ-017 instr_ready SHALL be 0 in every state except IDLE; instr_data SHALL be ignored when no handshake occurs.
REQ-018 DECODE transitions: LDI goes to WB; MOV and ADD go to RD_S; HLT goes to HALT.
REQ-019 RD_S: rsel=src; capture rdata as op_s; MOV goes to WB; ADD goes to RD_D.
REQ-020 RD_D: rsel=dst; capture rdata as op_d; go to WB.
REQ-021 WB: we=1, waddr=dst, wdata=result, instr_done=1 for exactly this cycle; go to IDLE.
REQ-022 Latency from the accept edge to the WB cycle SHALL be: LDI 2 cycles, MOV 3 cycles, ADD 4 cycles; one IDLE cycle follows every WB.
REQ-023 MOV and ADD with src==dst SHALL be legal; ADD R0,R0 doubles R0.
REQ-024 ADD overflow SHALL wrap modulo 2^DW without error.
REQ-025 HALT: halted=1, instr_ready=0, we=0; the sequencer stays in HALT until reset.
REQ-026 we SHALL be 0 in every state other than WB; rsel SHALL be 0 outside RD_S and RD_D.

Reset
REQ-027 While reset=0 at an edge: state=IDLE; we, instr_done, halted, rsel, waddr, wdata and the latched instruction all 0.
REQ-028 Reset in any state, including mid-instruction, SHALL abandon the instruction with no write.
REQ-029 instr_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-030 With SEQ_CARRY_FLAG_EN defined: add output carry (1 bit, reset 0), updated only at ADD WB to the carry-out of the add and held otherwise.
REQ-031 Without SEQ_CARRY_FLAG_EN: there is no carry port and no carry logic.

Structure
REQ-032 Shared package seq_pkg SHALL hold the opcode constants, the state enum typedef and the instruction field positions.
REQ-033 Sub-module instr_decode (combinational; opcode, dst, src, imm out) SHALL be instantiated once.

Verification
REQ-034 0x0A then 0x25 -> WB writes (waddr 0, wdata 0x0A), then (waddr 1, wdata 0x05); each WB occurs 2 cycles after its accept edge.
REQ-035 ADD 0x90 with bench regfile R0=0x0A, R1=0x05 -> rsel 1 then 0, then WB waddr 0, wdata 0x0F, 4 cycles after accept.
REQ-036 ADD with R0=0xFF, R1=0x02 -> wdata 0x01; with SEQ_CARRY_FLAG_EN, carry=1.
REQ-037 MOV 0x60 with R0=0x0F -> WB waddr 1, wdata 0x0F; instr_ready=0 during the three busy cycles.
REQ-038 HLT 0xC0 -> halted=1, instr_ready=0; a following instr_valid with 0x0A produces no we over 20 cycles.
REQ-039 Reset=0 during RD_D of an ADD -> no we pulse; IDLE with instr_ready=1 in the first cycle after reset=1.
